// File: rtl/embertrail_dmem_arbiter.sv
// embertrail_dmem_arbiter
// Shares one single-ported synchronous data memory between the two issue
// slots of the Embertrail dual-issue control unit. A packet of up to two
// requests is captured in IDLE and serviced slot 1 first, slot 2 second.
// The control unit is stalled while the packet is in flight. A saturating
// counter records packets in which both slots requested.
//
// Ports
//   iClock, iReset            clock, synchronous active-high reset
//   iReq1/iRW1/iAddr1/iWData1 slot 1 request (RW: 1 = store, 0 = load)
//   iReq2/iRW2/iAddr2/iWData2 slot 2 request
//   iMemRData                 memory read data, valid the cycle after a load
//   oMemEn/oMemWE/oMemAddr/oMemWData  memory port (zero when not accessing)
//   oBusy                     stall to the control unit
//   oDone                     one-cycle packet-complete pulse
//   oRData1/oRData2           per-slot load results
//   oConflictCnt              saturating count of dual-slot packets
module embertrail_dmem_arbiter #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16,
  parameter int CNT_W  = 16
) (
  input  logic              iClock,
  input  logic              iReset,
  input  logic              iReq1,
  input  logic              iRW1,
  input  logic [ADDR_W-1:0] iAddr1,
  input  logic [DATA_W-1:0] iWData1,
  input  logic              iReq2,
  input  logic              iRW2,
  input  logic [ADDR_W-1:0] iAddr2,
  input  logic [DATA_W-1:0] iWData2,
  input  logic [DATA_W-1:0] iMemRData,
  output logic              oMemEn,
  output logic              oMemWE,
  output logic [ADDR_W-1:0] oMemAddr,
  output logic [DATA_W-1:0] oMemWData,
  output logic              oBusy,
  output logic              oDone,
  output logic [DATA_W-1:0] oRData1,
  output logic [DATA_W-1:0] oRData2,
  output logic [CNT_W-1:0]  oConflictCnt
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ACC1 = 3'd1,
    ACC2 = 3'd2,
    FIN  = 3'd3,
    DONE = 3'd4
  } state_t;

  state_t              state_q;
  logic                rw1_q, rw2_q;
  logic [ADDR_W-1:0]   addr1_q, addr2_q;
  logic [DATA_W-1:0]   wdata1_q, wdata2_q;
  logic                pend1_q, pend2_q;
  // Set for the cycle in which the load issued by the previous ACC state
  // returns its data on iMemRData.
  logic                cap1_q, cap2_q;
  logic [DATA_W-1:0]   rdata1_q, rdata2_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                busy_q, done_q;

  always_ff @(posedge iClock) begin
    if (iReset) begin
      state_q  <= IDLE;
      rw1_q    <= 1'b0;
      rw2_q    <= 1'b0;
      addr1_q  <= '0;
      addr2_q  <= '0;
      wdata1_q <= '0;
      wdata2_q <= '0;
      pend1_q  <= 1'b0;
      pend2_q  <= 1'b0;
      cap1_q   <= 1'b0;
      cap2_q   <= 1'b0;
      rdata1_q <= '0;
      rdata2_q <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      cap1_q <= (state_q == ACC1) && pend1_q && !rw1_q;
      cap2_q <= (state_q == ACC2) && pend2_q && !rw2_q;
      if (cap1_q) rdata1_q <= iMemRData;
      if (cap2_q) rdata2_q <= iMemRData;

      unique case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (iReq1 || iReq2) begin
            if (iReq1) begin
              rw1_q    <= iRW1;
              addr1_q  <= iAddr1;
              wdata1_q <= iWData1;
            end
            if (iReq2) begin
              rw2_q    <= iRW2;
              addr2_q  <= iAddr2;
              wdata2_q <= iWData2;
            end
            pend1_q <= iReq1;
            pend2_q <= iReq2;
            state_q <= iReq1 ? ACC1 : ACC2;
            busy_q  <= 1'b1;
            if (iReq1 && iReq2 && (cnt_q != '1)) cnt_q <= cnt_q + CNT_W'(1);
          end else begin
            busy_q <= 1'b0;
          end
        end
        ACC1: begin
          state_q <= pend2_q ? ACC2 : FIN;
          busy_q  <= 1'b1;
        end
        ACC2: begin
          state_q <= FIN;
          busy_q  <= 1'b1;
        end
        FIN: begin
          state_q <= DONE;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
        end
        DONE: begin
          state_q <= IDLE;
          pend1_q <= 1'b0;
          pend2_q <= 1'b0;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  // Memory port is decoded straight from state so the access lands in the
  // ACC cycle itself; reset masks it so nothing is issued in a reset cycle.
  always_comb begin
    oMemEn    = 1'b0;
    oMemWE    = 1'b0;
    oMemAddr  = '0;
    oMemWData = '0;
    if (!iReset) begin
      if ((state_q == ACC1) && pend1_q) begin
        oMemEn    = 1'b1;
        oMemWE    = rw1_q;
        oMemAddr  = addr1_q;
        oMemWData = wdata1_q;
      end else if ((state_q == ACC2) && pend2_q) begin
        oMemEn    = 1'b1;
        oMemWE    = rw2_q;
        oMemAddr  = addr2_q;
        oMemWData = wdata2_q;
      end
    end
  end

  assign oBusy        = busy_q;
  assign oDone        = done_q;
  assign oRData1      = rdata1_q;
  assign oRData2      = rdata2_q;
  assign oConflictCnt = cnt_q;

endmodule

// File: tb/tb_embertrail_dmem_arbiter.sv
module tb_embertrail_dmem_arbiter;
  localparam int AW = 16;
  localparam int DW = 16;
  localparam int CW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          req1, rw1, req2, rw2;
  logic [AW-1:0] addr1, addr2;
  logic [DW-1:0] wd1, wd2;
  logic [DW-1:0] mem_rdata;
  logic          mem_en, mem_we, busy, done;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, rd1, rd2;
  logic [CW-1:0] ccnt;

  always #5 clk = ~clk;

  embertrail_dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .CNT_W(CW)) dut (
    .iClock(clk), .iReset(rst),
    .iReq1(req1), .iRW1(rw1), .iAddr1(addr1), .iWData1(wd1),
    .iReq2(req2), .iRW2(rw2), .iAddr2(addr2), .iWData2(wd2),
    .iMemRData(mem_rdata),
    .oMemEn(mem_en), .oMemWE(mem_we), .oMemAddr(mem_addr), .oMemWData(mem_wdata),
    .oBusy(busy), .oDone(done), .oRData1(rd1), .oRData2(rd2),
    .oConflictCnt(ccnt)
  );

  typedef struct {
    logic [AW-1:0] addr;
    logic          we;
    logic [DW-1:0] wdata;
  } acc_t;

  typedef struct {
    logic [DW-1:0] r1;
    logic [DW-1:0] r2;
    logic [CW-1:0] cnt;
    int            done_cyc;
    int            busy_len;
  } res_t;

  acc_t acc_q[$];
  res_t res_q[$];

  logic [DW-1:0] hw_mem  [65536];
  logic [DW-1:0] ref_mem [65536];
  logic [DW-1:0] m_r1, m_r2;
  int            m_cnt;
  int            cyc = 0;
  int            n_cmp = 0;
  int            n_fail = 0;
  int            busy_cnt = 0;

  function automatic logic [DW-1:0] init_val(int i);
    if (i == 16'h0010) return 16'h1234;
    return 16'((i * 37 + 11) ^ 16'h5A5A);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Synchronous single-port memory seen by the DUT.
  initial begin
    for (int i = 0; i < 65536; i++) hw_mem[i] = init_val(i);
    mem_rdata = '0;
    forever begin
      @(posedge clk);
      if (mem_en) begin
        if (mem_we) hw_mem[mem_addr] <= mem_wdata;
        else        mem_rdata        <= hw_mem[mem_addr];
      end
    end
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Monitor: compares every memory access and every completed packet
  // against what the reference model queued.
  initial forever begin
    @(negedge clk);
    if (rst) begin
      busy_cnt = 0;
    end else begin
      if (busy) busy_cnt++;
      if (mem_en) begin
        if (acc_q.size() == 0) begin
          n_cmp++; n_fail++;
          $display("FAIL unexpected_access: addr %h we %b data %h, expected none", mem_addr, mem_we, mem_wdata);
        end else begin
          acc_t a;
          a = acc_q.pop_front();
          check("acc_addr", 32'(mem_addr), 32'(a.addr));
          check("acc_we", 32'(mem_we), 32'(a.we));
          check("acc_wdata", 32'(mem_wdata), 32'(a.wdata));
        end
      end else begin
        check("idle_bus", {29'd0, mem_we, |mem_addr, |mem_wdata}, 32'd0);
      end
      if (done) begin
        if (res_q.size() == 0) begin
          n_cmp++; n_fail++;
          $display("FAIL unexpected_done: oDone high, expected no packet completion");
        end else begin
          res_t r;
          r = res_q.pop_front();
          check("rdata1", 32'(rd1), 32'(r.r1));
          check("rdata2", 32'(rd2), 32'(r.r2));
          check("conflict_cnt", 32'(ccnt), 32'(r.cnt));
          check("done_cycle", 32'(cyc), 32'(r.done_cyc));
          check("busy_len", 32'(busy_cnt), 32'(r.busy_len));
        end
        busy_cnt = 0;
      end
    end
  end

  // Reference model: apply the packet in program order to a plain array.
  task automatic model_packet(input logic r1, input logic w1, input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                              input logic r2, input logic w2, input logic [AW-1:0] a2, input logic [DW-1:0] d2);
    res_t r;
    acc_t a;
    if (r1) begin
      a.addr = a1; a.we = w1; a.wdata = d1;
      acc_q.push_back(a);
      if (w1) ref_mem[a1] = d1;
      else    m_r1 = ref_mem[a1];
    end
    if (r2) begin
      a.addr = a2; a.we = w2; a.wdata = d2;
      acc_q.push_back(a);
      if (w2) ref_mem[a2] = d2;
      else    m_r2 = ref_mem[a2];
    end
    if (r1 && r2 && m_cnt < (1 << CW) - 1) m_cnt++;
    r.r1 = m_r1;
    r.r2 = m_r2;
    r.cnt = CW'(m_cnt);
    r.done_cyc = cyc + ((r1 && r2) ? 4 : 3);
    r.busy_len = (r1 && r2) ? 3 : 2;
    res_q.push_back(r);
  endtask

  // Called #1 after a rising edge with the DUT idle; returns #1 after the
  // edge that ends the DONE cycle.
  task automatic send(input logic r1, input logic w1, input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                      input logic r2, input logic w2, input logic [AW-1:0] a2, input logic [DW-1:0] d2,
                      input bit poke);
    logic seen;
    model_packet(r1, w1, a1, d1, r2, w2, a2, d2);
    req1 = r1; rw1 = w1; addr1 = a1; wd1 = d1;
    req2 = r2; rw2 = w2; addr2 = a2; wd2 = d2;
    @(posedge clk); #1;
    req1 = 1'b0; req2 = 1'b0;
    if (poke) begin
      // Stray slot-1 store while the packet is in flight; must be ignored.
      @(posedge clk); #1;
      req1 = 1'b1; rw1 = 1'b1; addr1 = 16'h0033; wd1 = 16'hDEAD;
      @(posedge clk); #1;
      req1 = 1'b0;
    end
    seen = 1'b0;
    for (int i = 0; i < 8 && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    check("done_seen", 32'(seen), 32'd1);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 65536; i++) ref_mem[i] = init_val(i);
    m_r1 = '0; m_r2 = '0; m_cnt = 0;
    rst = 1'b1;
    req1 = 0; rw1 = 0; addr1 = '0; wd1 = '0;
    req2 = 0; rw2 = 0; addr2 = '0; wd2 = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_memen", 32'(mem_en), 32'd0);
    check("rst_rdata1", 32'(rd1), 32'd0);
    check("rst_rdata2", 32'(rd2), 32'd0);
    check("rst_cnt", 32'(ccnt), 32'd0);
    @(posedge clk); #1;

    // Directed packets.
    send(1, 0, 16'h0010, 16'h1111, 0, 0, 16'h0000, 16'h0000, 0);
    send(1, 1, 16'h0020, 16'hBEEF, 1, 0, 16'h0020, 16'h2222, 0);
    send(0, 0, 16'h0000, 16'h0000, 1, 1, 16'h0005, 16'h00AA, 0);
    send(1, 0, 16'h0020, 16'h3333, 1, 1, 16'h0020, 16'h4444, 1);
    send(1, 1, 16'h0040, 16'h5555, 1, 1, 16'h0040, 16'h6666, 0);
    send(1, 0, 16'h0040, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0);

    // Randomized packets over a small address window to force aliasing.
    for (int n = 0; n < 40; n++) begin
      logic r1, r2;
      r1 = 1'($urandom_range(0, 1));
      r2 = 1'($urandom_range(0, 1));
      if (!r1 && !r2) r1 = 1'b1;
      send(r1, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)), DW'($urandom),
           r2, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)), DW'($urandom),
           ($urandom_range(0, 3) == 0));
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #0;
    end

    // Reset in ACC1 of a dual packet: nothing may be issued, nothing completes.
    req1 = 1; rw1 = 1; addr1 = 16'h0060; wd1 = 16'h7777;
    req2 = 1; rw2 = 0; addr2 = 16'h0061; wd2 = 16'h8888;
    @(posedge clk); #1;
    req1 = 0; req2 = 0;
    rst = 1'b1;
    @(negedge clk);
    check("midrst_memen", 32'(mem_en), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    m_r1 = '0; m_r2 = '0; m_cnt = 0;
    @(negedge clk);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_cnt", 32'(ccnt), 32'd0);
    check("midrst_rdata1", 32'(rd1), 32'd0);
    check("midrst_rdata2", 32'(rd2), 32'd0);
    repeat (5) @(posedge clk);
    #1;

    // Five dual packets after reset: counter 1, 2, 3, 3, 3.
    for (int n = 0; n < 5; n++) begin
      send(1, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)), DW'($urandom),
           1, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)), DW'($urandom), 0);
    end

    repeat (4) @(posedge clk);
    @(negedge clk);
    check("acc_queue_drained", 32'(acc_q.size()), 32'd0);
    check("res_queue_drained", 32'(res_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/embertrail_dmem_arbiter.md
Name: embertrail_dmem_arbiter

Overview:
- Shares one single-ported, synchronous data memory between the two issue slots of the Embertrail dual-issue control unit.
- Accepts a memory request packet from slot 1 and/or slot 2 in one cycle and serialises the accesses, slot 1 first (program order).
- Stalls the control unit while accesses are in flight and returns the load data per slot.
- Keeps a saturating count of dual-slot conflicts for performance analysis.

Parameters:
- ADDR_W, 16, address width of each slot and of the memory port.
- DATA_W, 16, data width of each slot and of the memory port.
- CNT_W, 16, width of the conflict counter.

Ports:
- iClock  in  1  clock.
- iReset  in  1  synchronous, active-high reset.
- iReq1  in  1  slot 1 memory request (level).
- iRW1  in  1  slot 1 direction: 1 = store, 0 = load.
- iAddr1  in  ADDR_W  slot 1 address.
- iWData1  in  DATA_W  slot 1 store data.
- iReq2, iRW2, iAddr2, iWData2  in  1/1/ADDR_W/DATA_W  same as slot 1, for slot 2.
- iMemRData  in  DATA_W  memory read data, valid the cycle after an enabled load.
- oMemEn  out  1  memory access enable.
- oMemWE  out  1  memory write enable.
- oMemAddr  out  ADDR_W  memory address.
- oMemWData  out  DATA_W  memory write data.
- oBusy  out  1  stall to the control unit.
- oDone  out  1  one-cycle pulse: packet complete, load data valid.
- oRData1  out  DATA_W  slot 1 load result.
- oRData2  out  DATA_W  slot 2 load result.
- oConflictCnt  out  CNT_W  number of packets with both slots requesting, saturating.

Behaviour:
- States: IDLE, ACC1, ACC2, FIN, DONE. Reset state is IDLE.
- Reset values: all registers 0, so oRData1 = oRData2 = 0 and oConflictCnt = 0. oMemEn, oMemWE, oBusy and oDone are all 0.
- IDLE, edge with iReq1 | iReq2:
  - Latch RW, address and write data of each requesting slot into hold registers.
  - Set pend1 = iReq1 and pend2 = iReq2.
  - Next state is ACC1 if iReq1, else ACC2.
  - If both requests are set and oConflictCnt < all-ones, increment oConflictCnt.
- IDLE with no request: stay in IDLE. Requests are sampled only in IDLE and ignored in every other state.
- ACC1:
  - oMemEn = 1, oMemAddr = held addr1, oMemWE = held rw1, oMemWData = held wdata1.
  - Next state is ACC2 if pend2, else FIN.
- ACC2: same as ACC1 using slot 2 hold registers. Next state is FIN.
- Load capture, the cycle after each access:
  - Slot 1 load: the cycle after ACC1 (ACC2 or FIN), oRData1 <= iMemRData at the end of that cycle.
  - Slot 2 load: the cycle after ACC2 (FIN), oRData2 <= iMemRData at the end of that cycle.
- oRData of a slot with a store or no request is unchanged (holds its previous value).
- FIN: no memory access (oMemEn = 0). Next state is DONE.
- DONE: oDone = 1, oBusy = 0. Next state is IDLE, and pend flags clear.
- oBusy = 1 in ACC1, ACC2 and FIN; 0 in IDLE and DONE.
- The requester must deassert iReq by DONE. A request still high in IDLE is a new packet.
- Memory outputs are combinational from state and hold registers, gated by ~iReset. oMemAddr and oMemWData = 0 when oMemEn = 0.
- Latency:
  - Single-slot packet: capture edge, then ACC, FIN, DONE. oDone is high in the 3rd cycle after capture.
  - Dual-slot packet: oDone is high in the 4th cycle.
- Same-address ordering follows from serialisation:
  - Slot 1 store then slot 2 load to the same address: the load returns the new data.
  - Dual store to the same address: the slot 2 value persists.
  - Slot 1 load then slot 2 store: the load returns the old data.
- Reset mid-operation: return to IDLE at the edge and drop pending accesses. No access is issued in the reset cycle. Counter and load data registers clear.
- Counter saturates at 2^CNT_W-1 and never wraps.

Test Plan:
- Single load: slot 1 load, addr 0x0010, memory holds 0x1234 -> one access at 0x0010 with WE = 0; oDone 3 cycles after capture; oRData1 = 0x1234; oRData2 unchanged; oConflictCnt = 0.
- Dual store/load same address: slot 1 stores 0xBEEF @0x0020 and slot 2 loads @0x0020 -> write in ACC1, read in ACC2; oRData2 = 0xBEEF; oDone in cycle 4; oConflictCnt = 1.
- Slot 2 only: slot 2 stores 0x00AA @0x0005 -> ACC1 skipped; single write with addr 0x0005 and data 0x00AA; oBusy high for exactly 2 cycles.
- Request outside IDLE: iReq1 pulsed during ACC2 with addr 0x0033 -> no access to 0x0033; packet completes unchanged.
- Reset mid-operation: iReset asserted in ACC1 of a dual packet -> next cycle IDLE; oMemEn = 0 in the reset cycle; no ACC2 access; oDone never asserts; counter = 0.
- Counter saturation: CNT_W = 2, five dual packets -> oConflictCnt reads 1, 2, 3, 3, 3.
